spi_miso_rx_fifo: RTL and testbench

Parametrised next-generation SPI MISO receive path for the SPI design.
- Deserialises spi_miso_in into DATA_W-bit words while spi_cs is low, with selectable bit order.
- Buffers completed words in a first-word-fall-through FIFO with level, overflow and framing-error reporting.
- Replaces the fixed 8-bit, unbuffered MISO capture used so far.
- Sits between the SPI pins and the controller's read logic, single clock domain on spi_clk.

---
 rtl/spi_miso_rx_fifo.sv | 158 +++++++++++++++
 tb/tb_spi_miso_rx_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_miso_rx_fifo.sv
// SPI MISO receive path: deserialises framed serial data and buffers words in a FWFT FIFO.
// Optional even-parity frame bit is enabled with the SPI_MISO_PARITY_EN macro.
module spi_miso_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     spi_clk,
  input  logic                     n_reset,
  input  logic                     spi_cs,
  input  logic                     spi_miso_in,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     rx_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef SPI_MISO_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d, shifted;
  logic                frame_err_q, frame_err_d;
  logic                push;
  logic [DATA_W-1:0]   word;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                pop, wr, full, drop;

  if (MSB_FIRST != 0) begin : g_msb
    assign shifted = {shift_q[DATA_W-2:0], spi_miso_in};
  end else begin : g_lsb
    assign shifted = {spi_miso_in, shift_q[DATA_W-1:1]};
  end

`ifdef SPI_MISO_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  // Receiver: IDLE waits for chip select; SHIFT counts bits and emits completed words.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    word        = '0;
`ifdef SPI_MISO_PARITY_EN
    par_err_d   = 1'b0;
`endif
    if (state_q == SHIFT && spi_cs) begin
      state_d     = IDLE;
      cnt_d       = '0;
      shift_d     = '0;
      frame_err_d = (cnt_q != '0);
    end else if (!spi_cs) begin
      state_d = SHIFT;
      if (cnt_q == CW'(FRAME_LEN - 1)) begin
        cnt_d   = '0;
        shift_d = '0;
`ifdef SPI_MISO_PARITY_EN
        // Last bit is the even-parity bit; it is checked, never stored.
        word = shift_q;
        if (^{shift_q, spi_miso_in}) par_err_d = 1'b1;
        else                         push      = 1'b1;
`else
        word = shifted;
        push = 1'b1;
`endif
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shift_d = shifted;
      end
    end
  end

  always_ff @(posedge spi_clk or posedge n_reset) begin
    if (n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SPI_MISO_PARITY_EN
  always_ff @(posedge spi_clk or posedge n_reset) begin
    if (n_reset) par_err_q <= 1'b0;
    else         par_err_q <= par_err_d;
  end
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // FIFO: a pop frees a slot in the same cycle, so a push into a full FIFO with a pop is kept.
  assign full = (level_q == LW'(DEPTH));
  assign pop  = rd_en && (level_q != '0);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_comb begin
    level_d = level_q + LW'(wr) - LW'(pop);
    ovf_d   = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge spi_clk or posedge n_reset) begin
    if (n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_valid     = (level_q != '0);
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_full    = full;
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;
  assign frame_err    = frame_err_q;
  assign rx_state_dbg = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_miso_rx_fifo.sv
// Bench for spi_miso_rx_fifo: two instances (MSB-first and LSB-first) share stimulus and
// are checked against a queue-based model, plus table vectors and directed corner cases.
module tb_spi_miso_rx_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef SPI_MISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1, miso = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0;

  logic [W-1:0] m_data, l_data;
  logic         m_valid, l_valid, m_full, l_full, m_ovf, l_ovf;
  logic         m_ferr, l_ferr, m_perr, l_perr, m_dbg, l_dbg;
  logic [2:0]   m_level, l_level;

  int total = 0;
  int bad   = 0;

  // model state
  bit           cur_bits[$];
  logic [W-1:0] exp_q_m[$];
  logic [W-1:0] exp_q_l[$];
  bit           mdl_ovf, mdl_ferr, mdl_perr;

  typedef struct {
    logic [7:0] seq;        // seq[7] is the first bit on the wire
    bit         clr_first;
    bit         rd_last;
    bit         clr_last;
    logic [7:0] head_m;
    logic [7:0] head_l;
    int         level;
    bit         full;
    bit         ovf;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_miso_rx_fifo #(.DATA_W(W), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
    .spi_clk(clk), .n_reset(rst), .spi_cs(cs), .spi_miso_in(miso), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(m_data), .rd_valid(m_valid), .fifo_full(m_full),
    .fifo_level(m_level), .overflow(m_ovf), .frame_err(m_ferr), .parity_err(m_perr),
    .rx_state_dbg(m_dbg));

  spi_miso_rx_fifo #(.DATA_W(W), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
    .spi_clk(clk), .n_reset(rst), .spi_cs(cs), .spi_miso_in(miso), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(l_data), .rd_valid(l_valid), .fifo_full(l_full),
    .fifo_level(l_level), .overflow(l_ovf), .frame_err(l_ferr), .parity_err(l_perr),
    .rx_state_dbg(l_dbg));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur_bits.delete();
    exp_q_m.delete();
    exp_q_l.delete();
    mdl_ovf  = 1'b0;
    mdl_ferr = 1'b0;
    mdl_perr = 1'b0;
  endtask

  // One rising edge of the receiver+FIFO, stated as rules on whole words.
  task automatic model_edge(input bit c, input bit b, input bit rd, input bit clr);
    bit           do_pop, do_push, set_ovf;
    logic [W-1:0] wm, wl;
    int           ones;
    do_pop   = rd && (exp_q_m.size() != 0);
    do_push  = 1'b0;
    set_ovf  = 1'b0;
    mdl_ferr = 1'b0;
    mdl_perr = 1'b0;
    wm = '0;
    wl = '0;
    if (c) begin
      if (cur_bits.size() != 0) mdl_ferr = 1'b1;
      cur_bits.delete();
    end else begin
      cur_bits.push_back(b);
      if (cur_bits.size() == FL) begin
        ones = 0;
        for (int i = 0; i < FL; i++) ones += int'(cur_bits[i]);
        for (int i = 0; i < W; i++) begin
          wm += (W'(cur_bits[i]) << (W - 1 - i));
          wl += (W'(cur_bits[i]) << i);
        end
        if (FL > W && (ones % 2) != 0) mdl_perr = 1'b1;
        else                           do_push  = 1'b1;
        cur_bits.delete();
      end
    end
    if (do_pop) begin
      void'(exp_q_m.pop_front());
      void'(exp_q_l.pop_front());
    end
    if (do_push) begin
      if (exp_q_m.size() < DEPTH) begin
        exp_q_m.push_back(wm);
        exp_q_l.push_back(wl);
      end else begin
        set_ovf = 1'b1;
      end
    end
    if (set_ovf)  mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q_m.size();
    check("valid_m", m_valid, n != 0);
    check("valid_l", l_valid, n != 0);
    check("data_m",  m_data, (n != 0) ? exp_q_m[0] : 8'h00);
    check("data_l",  l_data, (n != 0) ? exp_q_l[0] : 8'h00);
    check("level_m", m_level, n);
    check("level_l", l_level, n);
    check("full_m",  m_full, n == DEPTH);
    check("ovf_m",   m_ovf, mdl_ovf);
    check("ovf_l",   l_ovf, mdl_ovf);
    check("ferr_m",  m_ferr, mdl_ferr);
    check("ferr_l",  l_ferr, mdl_ferr);
    check("perr_m",  m_perr, mdl_perr);
  endtask

  task automatic tick(input bit c, input bit b, input bit rd, input bit clr);
    cs      = c;
    miso    = b;
    rd_en   = rd;
    clr_ovf = clr;
    model_edge(c, b, rd, clr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [7:0] seq, input bit clr_first, input bit rd_last,
                            input bit clr_last);
    bit fb[$];
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      fb.push_back(seq[7-i]);
      ones += int'(seq[7-i]);
    end
`ifdef SPI_MISO_PARITY_EN
    fb.push_back(bit'(ones % 2));
`endif
    for (int i = 0; i < fb.size(); i++)
      tick(1'b0, fb[i], rd_last && (i == fb.size() - 1),
           (clr_first && i == 0) || (clr_last && i == fb.size() - 1));
  endtask

`ifdef SPI_MISO_PARITY_EN
  task automatic send_frame_par(input logic [7:0] seq, input bit pbit);
    for (int i = 0; i < 8; i++) tick(1'b0, seq[7-i], 1'b0, 1'b0);
    tick(1'b0, pbit, 1'b0, 1'b0);
  endtask
`endif

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", {m_valid, l_valid}, 2'b00);
    check("rst_data",  {m_data, l_data}, 16'h0000);
    check("rst_level", {m_level, l_level}, 6'd0);
    check("rst_flags", {m_full, m_ovf, m_ferr, m_perr, m_dbg}, 5'b0);
    cs = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0; miso = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h80, 0, 0, 0, 8'h80, 8'h01, 1, 0, 0};
    vecs[1] = '{8'h02, 0, 0, 0, 8'h80, 8'h01, 2, 0, 0};
    vecs[2] = '{8'h03, 0, 0, 0, 8'h80, 8'h01, 3, 0, 0};
    vecs[3] = '{8'hA5, 0, 0, 0, 8'h80, 8'h01, 4, 1, 0};
    vecs[4] = '{8'h3C, 0, 0, 1, 8'h80, 8'h01, 4, 1, 1};  // drop wins over clr_ovf
    vecs[5] = '{8'h11, 1, 1, 0, 8'h02, 8'h40, 4, 1, 0};  // push into full with pop

    model_reset();
    #1;
    check("init_valid", {m_valid, l_valid}, 2'b00);
    check("init_level", m_level, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table vectors: back-to-back frames with cs held low.
    foreach (vecs[i]) begin
      send_frame(vecs[i].seq, vecs[i].clr_first, vecs[i].rd_last, vecs[i].clr_last);
      check($sformatf("vec%0d_head_m", i), m_data, vecs[i].head_m);
      check($sformatf("vec%0d_head_l", i), l_data, vecs[i].head_l);
      check($sformatf("vec%0d_level", i), m_level, vecs[i].level);
      check($sformatf("vec%0d_full", i), m_full, vecs[i].full);
      check($sformatf("vec%0d_ovf", i), m_ovf, vecs[i].ovf);
    end

    // Drain: remaining order 0x03, 0xA5, 0x11 (LSB view 0xC0, 0xA5, 0x88).
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("drain1_l", l_data, 8'hC0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("drain2_m", m_data, 8'hA5);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("drain3_l", l_data, 8'h88);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("drain_empty", m_valid, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("underflow_level", m_level, 3'd0);

    // LSB-first stream 0x40 then 0xC0, then two pops.
    send_frame(8'h02, 0, 0, 0);
    send_frame(8'h03, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("lsb_head0", l_data, 8'h40);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("lsb_head1", l_data, 8'hC0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("lsb_empty", l_valid, 1'b0);

    // Partial frame: cs rises after 3 bits.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", m_ferr, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("ferr_single", m_ferr, 1'b0);
    check("ferr_level", m_level, 3'd0);
    send_frame(8'hB6, 0, 0, 0);
    check("after_ferr_m", m_data, 8'hB6);
    check("after_ferr_l", l_data, 8'h6D);

`ifdef SPI_MISO_PARITY_EN
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    send_frame_par(8'h80, 1'b0);
    check("par_bad_pulse", m_perr, 1'b1);
    check("par_bad_level", m_level, 3'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("par_single", m_perr, 1'b0);
    send_frame_par(8'h80, 1'b1);
    check("par_good_level", m_level, 3'd1);
    check("par_good_data", m_data, 8'h80);
`endif

    // Async reset mid-word with two words buffered.
    apply_reset();
    send_frame(8'h5A, 0, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_level", m_level, 3'd2);
    apply_reset();
    send_frame(8'hE1, 0, 0, 0);
    check("post_rst_data", m_data, 8'hE1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++)
      tick($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
